reg_dump_ctrl: RTL and testbench
================================

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 Parameter: NREGS, 32, number of register-file entries.
REQ-002 Parameter: AW, 5, register index width; the block SHALL require 2**AW == NREGS.
REQ-003 Parameter: DW, 32, register data width.
REQ-004 Port: CLK  in  1  single clock; all state changes on posedge CLK.
REQ-005 Port: RST  in  1  asynchronous, active-high reset.
REQ-006 Port: START  in  1  one-cycle request to begin a dump.
REQ-007 Port: ABORT  in  1  terminate the current dump.
REQ-008 Port: FIRST_IDX  in  AW  first index to dump; sampled when START is accepted.
REQ-009 Port: LAST_IDX  in  AW  last index to dump; sampled when START is accepted.
REQ-010 Port: RR  out  AW  read-register index driven to the register file's read port.
REQ-011 Port: RD  in  DW  combinational read data returned for RR in the same cycle.
REQ-012 Port: OUT_VALID  out  1  output beat valid.
REQ-013 Port: OUT_READY  in  1  consumer accepts the beat.
REQ-014 Port: OUT_IDX  out  AW  index of the beat.
REQ-015 Port: OUT_DATA  out  DW  data of the beat.
REQ-016 Port: OUT_LAST  out  1  marks the final beat of the dump.
REQ-017 Port: BUSY  out  1  high in every state except IDLE.
REQ-018 Port: DONE  out  1  one-cycle pulse after the final beat is accepted.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, SEND, CSUM (macro only) and FIN.
- IDLE: START=1 latches FIRST_IDX/LAST_IDX, loads ptr=FIRST_IDX, and moves to READ.
- READ: RR=ptr; RD is registered into OUT_DATA and ptr into OUT_IDX; moves to SEND.
- SEND: OUT_VALID=1; on OUT_VALID&&OUT_READY, if ptr==last then go to CSUM (macro) or FIN, else ptr=ptr+1 modulo NREGS and go to READ.
- FIN: DONE=1 for exactly one cycle, then IDLE.
REQ-020 With START at cycle t, RR SHALL equal FIRST_IDX at t+1 and OUT_VALID SHALL be high from t+2; each beat costs a minimum of 2 cycles.
REQ-021 Wrap-around: if LAST_IDX < FIRST_IDX, the walk SHALL proceed FIRST..NREGS-1, then 0..LAST_IDX.
REQ-022 If FIRST_IDX == LAST_IDX, exactly one beat SHALL be emitted, with OUT_LAST=1.
REQ-023 OUT_LAST SHALL be high only on the final beat.
REQ-024 While OUT_VALID=1 and OUT_READY=0, OUT_IDX, OUT_DATA and OUT_LAST SHALL be held stable.
REQ-025 START while BUSY=1 SHALL be ignored.
REQ-026 START in the same cycle as the FIN→IDLE transition SHALL be ignored; START is accepted only in IDLE.
REQ-027 ABORT in any non-IDLE state SHALL force IDLE on the next edge, with OUT_VALID=0 and no DONE; ABORT has priority over the handshake in the same cycle.
REQ-028 ABORT in IDLE SHALL have no effect.
REQ-029 RR SHALL hold its last value outside READ.

Reset
REQ-030 Asserting RST SHALL immediately force: state=IDLE, OUT_VALID=0, OUT_LAST=0, DONE=0, BUSY=0, RR=0, OUT_IDX=0, OUT_DATA=0, ptr=0 and csum=0.
REQ-031 RST asserted mid-dump SHALL discard the dump with no DONE; after release, the block waits for a new START.

Configuration
REQ-032 The macro REG_DUMP_CSUM_EN SHALL control the checksum beat.
- Defined: the block keeps csum = XOR of all emitted data beats, cleared on START. After the last register beat is accepted, it emits one extra beat in CSUM with OUT_IDX=0, OUT_DATA=csum and OUT_LAST=1; register beats then carry OUT_LAST=0.
- Undefined: the CSUM state and the csum register are absent, and the last register beat carries OUT_LAST=1.

Structure
REQ-033 Package reg_dump_pkg SHALL hold the state typedef and the NREGS/AW/DW default constants.
REQ-034 The design SHALL be a single module with no sub-module; the register file is external to the block.

Verification
REQ-035 Test setup: register file after its reset (reg[i]=i), OUT_READY=1, macro undefined. Dump FIRST=0, LAST=31 -> 32 beats with idx=data=0..31, LAST only on idx 31, DONE at cycle t+65.
REQ-036 Wrap: FIRST=30, LAST=1 -> beats with idx 30, 31, 0, 1; OUT_LAST on idx 1.
REQ-037 Backpressure: OUT_READY low for 3 cycles on beat idx 5 -> idx 5 and data 5 held stable, no beat dropped or duplicated.
REQ-038 ABORT during the beat with idx 10 -> IDLE next cycle, no DONE; a following START with FIRST=LAST=7 -> a single beat with data 7 and OUT_LAST=1.
REQ-039 RST asserted mid-dump, plus START while BUSY -> all outputs 0 immediately on RST; the START while BUSY is ignored.
REQ-040 Macro defined, FIRST=0, LAST=3 -> data beats 0..3, then a checksum beat with data 0x0 (0^1^2^3) and OUT_LAST=1.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// ============================================================================
// Module   : reg_dump_pkg
// Purpose  : Shared types and default sizing for the register-dump
//            controller: FSM state encoding and the NREGS/AW/DW defaults.
// Macro    : REG_DUMP_CSUM_EN -- adds the CSUM state and a trailing XOR
//            checksum beat after the last register beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_dump_pkg;

  // Default geometry: 32 entries of 32 bits, 5-bit index.
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;

  // Compile-time view of the checksum option, usable in expressions.
`ifdef REG_DUMP_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  // Controller states. CSUM exists only when the checksum beat is built in.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_FIN  = 3'd3
`ifdef REG_DUMP_CSUM_EN
    ,
    ST_CSUM = 3'd4
`endif
  } state_t;

endpackage : reg_dump_pkg

`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
// ============================================================================
// Module   : reg_dump_ctrl
// Purpose  : Walks an index range of an external register file and streams
//            each entry out as a valid/ready beat (index + data). The range
//            wraps modulo NREGS when LAST_IDX < FIRST_IDX. Each beat takes a
//            READ cycle (drive RR, capture RD) and at least one SEND cycle.
// Macro    : REG_DUMP_CSUM_EN -- when defined, a final beat carrying the XOR
//            of all emitted data follows the register beats (OUT_IDX=0,
//            OUT_LAST=1); register beats then never carry OUT_LAST.
// Ports    :
//   CLK        in   clock, all state changes on rising edge
//   RST        in   asynchronous active-high reset
//   START      in   begin a dump (accepted only in IDLE)
//   ABORT      in   drop the current dump, return to IDLE without DONE
//   FIRST_IDX  in   [AW] first index, sampled with START
//   LAST_IDX   in   [AW] last index, sampled with START
//   RR         out  [AW] register-file read index
//   RD         in   [DW] combinational read data for RR
//   OUT_VALID  out  beat valid
//   OUT_READY  in   consumer accepts the beat
//   OUT_IDX    out  [AW] beat index
//   OUT_DATA   out  [DW] beat data
//   OUT_LAST   out  final beat of the dump
//   BUSY       out  high whenever not IDLE
//   DONE       out  one-cycle pulse after the final beat is accepted
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump_ctrl
  import reg_dump_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic [AW-1:0] FIRST_IDX,
  input  logic [AW-1:0] LAST_IDX,
  output logic [AW-1:0] RR,
  input  logic [DW-1:0] RD,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [AW-1:0] OUT_IDX,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_LAST,
  output logic          BUSY,
  output logic          DONE
);

  // The pointer relies on natural AW-bit wrap to implement "modulo NREGS".
  generate
    if (2**AW != NREGS) begin : g_bad_params
      $error("reg_dump_ctrl: NREGS must equal 2**AW");
    end
  endgenerate

  state_t        r_state;
  state_t        w_next_state;

  logic [AW-1:0] r_ptr;        // index currently being read / sent
  logic [AW-1:0] r_last;       // last index, latched at START
  logic [AW-1:0] r_out_idx;
  logic [DW-1:0] r_out_data;
  logic          r_out_last;

  logic          w_start;      // START accepted this cycle
  logic          w_accept;     // beat handshake that actually takes effect
  logic          w_at_last;    // pointer sits on the final register index

`ifdef REG_DUMP_CSUM_EN
  logic [DW-1:0] r_csum;       // running XOR of accepted register beats
`endif

  assign w_at_last = (r_ptr == r_last);

  // The pointer only moves on entry to READ, so driving RR from it directly
  // gives the required "hold outside READ" behaviour without another flop.
  assign RR       = r_ptr;
  assign OUT_IDX  = r_out_idx;
  assign OUT_DATA = r_out_data;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    OUT_VALID    = 1'b0;
    BUSY         = 1'b1;
    DONE         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          w_start      = 1'b1;
          w_next_state = ST_READ;
        end
      end

      ST_READ: begin
        w_next_state = ST_SEND;
      end

      ST_SEND: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          w_accept = 1'b1;
          if (w_at_last) begin
`ifdef REG_DUMP_CSUM_EN
            w_next_state = ST_CSUM;
`else
            w_next_state = ST_FIN;
`endif
          end else begin
            w_next_state = ST_READ;
          end
        end
      end

`ifdef REG_DUMP_CSUM_EN
      ST_CSUM: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          w_accept     = 1'b1;
          w_next_state = ST_FIN;
        end
      end
`endif

      ST_FIN: begin
        DONE         = 1'b1;
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // ABORT wins over any handshake seen in the same cycle; in IDLE it is
    // simply ignored.
    if (ABORT && (r_state != ST_IDLE)) begin
      w_next_state = ST_IDLE;
      w_accept     = 1'b0;
    end

    // The last flag register keeps its value after the beat; gating with
    // OUT_VALID keeps OUT_LAST confined to the final beat itself.
    OUT_LAST = r_out_last & OUT_VALID;
  end

  // --------------------------------------------------------------------------
  // Datapath: pointer, captured beat, optional checksum
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr      <= '0;
      r_last     <= '0;
      r_out_idx  <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      if (w_start) begin
        r_ptr  <= FIRST_IDX;
        r_last <= LAST_IDX;
`ifdef REG_DUMP_CSUM_EN
        r_csum <= '0;
`endif
      end

      // Capture the combinational read data together with its index. With
      // the checksum enabled the trailing checksum beat owns OUT_LAST.
      if (r_state == ST_READ) begin
        r_out_idx  <= r_ptr;
        r_out_data <= RD;
        r_out_last <= w_at_last & ~CSUM_EN;
      end

      if (w_accept && (r_state == ST_SEND)) begin
        if (!w_at_last) begin
          r_ptr <= r_ptr + AW'(1);
        end
`ifdef REG_DUMP_CSUM_EN
        r_csum <= r_csum ^ r_out_data;
        // Load the checksum beat directly, folding in the beat just accepted.
        if (w_at_last) begin
          r_out_idx  <= '0;
          r_out_data <= r_csum ^ r_out_data;
          r_out_last <= 1'b1;
        end
`endif
      end
    end
  end

endmodule : reg_dump_ctrl

`default_nettype wire

// File: tb/tb_reg_dump_ctrl.sv
// ============================================================================
// Module   : tb_reg_dump_ctrl
// Purpose  : Self-checking bench for reg_dump_ctrl. Expected beats go into a
//            queue when a dump is issued; a monitor pops and compares every
//            accepted beat. Register file model holds reg[i] = i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_dump_ctrl;

`ifdef REG_DUMP_CSUM_EN
  localparam int CX = 1;   // extra cycle for the checksum beat
`else
  localparam int CX = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST, START, ABORT, OUT_READY;
  logic [4:0]  FIRST_IDX, LAST_IDX, RR, OUT_IDX;
  logic [31:0] RD, OUT_DATA;
  logic        OUT_VALID, OUT_LAST, BUSY, DONE;

  logic [31:0] regfile [32];

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t sb[$];

  int n_checks   = 0;
  int n_errors   = 0;
  int done_count = 0;

  always #5 CLK = ~CLK;

  assign RD = regfile[RR];

  reg_dump_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .ABORT     (ABORT),
    .FIRST_IDX (FIRST_IDX),
    .LAST_IDX  (LAST_IDX),
    .RR        (RR),
    .RD        (RD),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_IDX   (OUT_IDX),
    .OUT_DATA  (OUT_DATA),
    .OUT_LAST  (OUT_LAST),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Expected beats for a dump f..l (wrapping), plus the checksum beat.
  function automatic void push_dump(input logic [4:0] f, input logic [4:0] l);
    logic [4:0]  i  = f;
    logic [31:0] cs = '0;
    beat_t       b;
    for (int n = 0; n < 32; n++) begin
      b.idx  = i;
      b.data = regfile[i];
      b.last = (i == l) && (CX == 0);
      sb.push_back(b);
      cs = cs ^ regfile[i];
      if (i == l) break;
      i = i + 5'd1;
    end
    if (CX != 0) begin
      b.idx  = 5'd0;
      b.data = cs;
      b.last = 1'b1;
      sb.push_back(b);
    end
  endfunction

  function automatic void push_beat(input logic [4:0] idx, input logic [31:0] data,
                                    input logic last);
    beat_t b;
    b.idx  = idx;
    b.data = data;
    b.last = last;
    sb.push_back(b);
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: scoreboard compare on each accepted beat, hold-stability check
  // while stalled, DONE pulse counting.
  // --------------------------------------------------------------------------
  logic        held_v = 1'b0;
  logic [4:0]  held_idx;
  logic [31:0] held_data;
  logic        held_last;

  always @(negedge CLK) begin : mon
    beat_t e;
    if (!RST && OUT_VALID && OUT_READY && !ABORT) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: got idx %0d data 0x%0h, expected no beat",
                 OUT_IDX, OUT_DATA);
      end else begin
        e = sb.pop_front();
        check("beat_idx",  OUT_IDX,  e.idx);
        check("beat_data", OUT_DATA, e.data);
        check("beat_last", OUT_LAST, e.last);
      end
    end
    if (held_v && OUT_VALID) begin
      check("stall_idx",  OUT_IDX,  held_idx);
      check("stall_data", OUT_DATA, held_data);
      check("stall_last", OUT_LAST, held_last);
    end
    held_v    = !RST && OUT_VALID && !OUT_READY;
    held_idx  = OUT_IDX;
    held_data = OUT_DATA;
    held_last = OUT_LAST;
    if (DONE) done_count++;
  end

  // Called in the drive phase (just after a rising edge). START is high for
  // exactly one cycle (cycle t); returns in the drive phase of cycle t+1.
  task automatic issue_start(input logic [4:0] f, input logic [4:0] l);
    FIRST_IDX = f;
    LAST_IDX  = l;
    START     = 1'b1;
    @(posedge CLK); #1;
    START     = 1'b0;
  endtask

  // Scans falling edges starting at cycle t+start_k for DONE; expects it in
  // cycle t+exp_k, then IDLE the cycle after. Returns in the drive phase.
  task automatic wait_done(input string name, input int start_k, input int exp_k);
    int got = -1;
    for (int k = start_k; k <= start_k + 400; k++) begin
      @(negedge CLK);
      if (DONE) begin
        got = k;
        break;
      end
    end
    if (got < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_done_timeout: got no DONE, expected DONE at cycle t+%0d",
               name, exp_k);
    end else begin
      check({name, "_done_cycle"}, got, exp_k);
      @(negedge CLK);
      check({name, "_done_pulse"}, DONE, 1'b0);
      check({name, "_idle_busy"},  BUSY, 1'b0);
    end
    check({name, "_sb_empty"}, sb.size(), 0);
    @(posedge CLK); #1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : stim
    int dc;
    for (int i = 0; i < 32; i++) regfile[i] = 32'(i);
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; OUT_READY = 1'b1;
    FIRST_IDX = '0; LAST_IDX = '0;
    #2;
    check("rst_valid", OUT_VALID, 1'b0);
    check("rst_last",  OUT_LAST,  1'b0);
    check("rst_done",  DONE,      1'b0);
    check("rst_busy",  BUSY,      1'b0);
    check("rst_rr",    RR,        5'd0);
    check("rst_idx",   OUT_IDX,   5'd0);
    check("rst_data",  OUT_DATA,  32'd0);
    repeat (2) @(posedge CLK); #1;
    RST = 1'b0;

    // ABORT in IDLE does nothing
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    @(negedge CLK);
    check("abort_idle_busy", BUSY, 1'b0);
    @(posedge CLK); #1;

    // Full dump 0..31: RR at t+1, OUT_VALID from t+2, DONE at t+65
    push_dump(5'd0, 5'd31);
    issue_start(5'd0, 5'd31);
    @(negedge CLK);
    check("t1_rr_first", RR,        5'd0);
    check("t1_valid_t1", OUT_VALID, 1'b0);
    check("t1_busy",     BUSY,      1'b1);
    @(negedge CLK);
    check("t1_valid_t2", OUT_VALID, 1'b1);
    wait_done("full", 3, 65 + CX);

    // Wrap 30,31,0,1
    push_dump(5'd30, 5'd1);
    issue_start(5'd30, 5'd1);
    wait_done("wrap", 1, 9 + CX);

    // Backpressure on idx 5 (SEND at t+6), ready low t+6..t+8
    push_dump(5'd3, 5'd8);
    issue_start(5'd3, 5'd8);
    fork
      begin
        repeat (5) @(posedge CLK); #1;
        OUT_READY = 1'b0;
        @(negedge CLK);
        check("bp_valid", OUT_VALID, 1'b1);
        check("bp_idx",   OUT_IDX,   5'd5);
        check("bp_data",  OUT_DATA,  32'd5);
        repeat (3) @(posedge CLK); #1;
        OUT_READY = 1'b1;
      end
      wait_done("bp", 1, 16 + CX);
    join

    // ABORT on beat idx 10, then a single-beat dump of 7
    push_beat(5'd8, 32'd8, 1'b0);
    push_beat(5'd9, 32'd9, 1'b0);
    issue_start(5'd8, 5'd20);
    repeat (5) @(posedge CLK); #1;
    ABORT = 1'b1;
    @(negedge CLK);
    check("abort_on_valid", OUT_VALID, 1'b1);
    check("abort_on_idx",   OUT_IDX,   5'd10);
    dc = done_count;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    @(negedge CLK);
    check("abort_busy",  BUSY,      1'b0);
    check("abort_valid", OUT_VALID, 1'b0);
    repeat (4) @(negedge CLK);
    check("abort_no_done",  done_count, dc);
    check("abort_sb_empty", sb.size(),  0);
    @(posedge CLK); #1;
    push_dump(5'd7, 5'd7);
    issue_start(5'd7, 5'd7);
    wait_done("single", 1, 3 + CX);

    // START while busy ignored, then RST mid-dump
    push_beat(5'd0, 32'd0, 1'b0);
    push_beat(5'd1, 32'd1, 1'b0);
    issue_start(5'd0, 5'd31);
    @(posedge CLK); #1;               // cycle t+2
    @(posedge CLK); #1;               // cycle t+3 (READ of beat 1)
    FIRST_IDX = 5'd20; LAST_IDX = 5'd20; START = 1'b1;
    @(posedge CLK); #1;               // cycle t+4
    START = 1'b0;
    @(negedge CLK);
    check("busy_start_rr",  RR,        5'd1);
    check("busy_start_idx", OUT_IDX,   5'd1);
    check("busy_start_vld", OUT_VALID, 1'b1);
    @(posedge CLK); #1;               // cycle t+5
    @(posedge CLK); #1;               // cycle t+6 (SEND of beat 2)
    dc = done_count;
    RST = 1'b1;
    #1;
    check("mrst_valid", OUT_VALID, 1'b0);
    check("mrst_last",  OUT_LAST,  1'b0);
    check("mrst_done",  DONE,      1'b0);
    check("mrst_busy",  BUSY,      1'b0);
    check("mrst_rr",    RR,        5'd0);
    check("mrst_idx",   OUT_IDX,   5'd0);
    check("mrst_data",  OUT_DATA,  32'd0);
    repeat (2) @(posedge CLK); #1;
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    check("mrst_idle_busy", BUSY,       1'b0);
    check("mrst_no_done",   done_count, dc);
    check("mrst_sb_empty",  sb.size(),  0);
    @(posedge CLK); #1;

`ifdef REG_DUMP_CSUM_EN
    // 0..3 then checksum beat 0^1^2^3 = 0
    push_beat(5'd0, 32'd0, 1'b0);
    push_beat(5'd1, 32'd1, 1'b0);
    push_beat(5'd2, 32'd2, 1'b0);
    push_beat(5'd3, 32'd3, 1'b0);
    push_beat(5'd0, 32'h0, 1'b1);
    issue_start(5'd0, 5'd3);
    wait_done("csum", 1, 10);
`endif

    repeat (3) @(posedge CLK);
    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reg_dump_ctrl

`default_nettype wire
